data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the core's data bus: the slave end of the req/gnt/rvalid protocol driven by the core memory stage. It grants requests, commits byte/halfword/word stores with lane alignment, and returns aligned read words after a parameterised latency. It sits between the core's data port and an internal word-organised RAM array, and replaces the ideal testbench memory in core-level simulation and synthesis.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): bus data width; only 32 is supported.
- ADDR_WIDTH, `MEM_ADDR_WIDTH: byte-address width. The array depth is 2^(ADDR_WIDTH-2) words.
- RD_LATENCY, 1: cycles from read grant to rvalid. Legal range is 1..8.
- clk  in  1  single clock; all logic acts on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_req_i  in  1  request valid.
- data_wr_i  in  1  1 = store, 0 = load; qualified by data_req_i.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_wdata_i  in  DATA_WIDTH  store data, right-justified and not lane-shifted.
- data_write_transfer_i  in  `MEM_TRANSFER_WIDTH  store size: 00 byte, 01 half, 10 word, 11 reserved.
- data_gnt_o  out  1  request accepted this cycle; combinational.
- data_rvalid_o  out  1  read data valid; one-cycle pulse.
- data_rdata_o  out  DATA_WIDTH  full aligned word at addr[ADDR_WIDTH-1:2].
- data_err_o  out  1  one-cycle pulse: misaligned or reserved-size store was dropped.

## Operation
- **Ready condition:** ready = (state==IDLE) | (state==RESP).
- **Grant:** data_gnt_o = data_req_i & ready. A request with the grant low must be held by the initiator; no request is queued.
- **States:** IDLE, BUSY, RESP.
  - IDLE or RESP, read granted: the word is snapshotted into a read buffer at that edge. With RD_LATENCY==1 the next state is RESP; otherwise BUSY with cnt = RD_LATENCY-2.
  - IDLE or RESP, store granted: commits at that edge. Next state is IDLE.
  - IDLE or RESP, nothing granted: next state is IDLE.
  - BUSY: data_gnt_o is 0. When cnt==0 the next state is RESP; otherwise cnt decrements.
  - RESP: data_rvalid_o=1 and data_rdata_o = read buffer. A new grant is allowed in the same cycle, so with RD_LATENCY==1 back-to-back reads run at one per cycle.
- **Store lane alignment** (a = addr[1:0]):
  - Byte: wdata[7:0] is written to lane a, byte enable 1<<a.
  - Half: wdata[15:0] is written to lanes {a[1],1}:{a[1],0}, byte enable 0011<<a. Requires a[0]==0.
  - Word: byte enable 1111. Requires a==00.
  - Misaligned or reserved-size store: granted, but no bytes are written. data_err_o pulses in the next cycle.
- **Loads:** ignore addr[1:0] and data_write_transfer_i. The core performs sign/zero extraction.
- **Snapshot semantics:** a store granted in the RESP cycle after a read does not change that read's returned data. A read granted the cycle after a store returns the new data.
- **Array contents:** not reset. Only the control registers and outputs are reset.

## Timing
- **Reset values:** state=IDLE, cnt=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0. data_gnt_o=0 while rst=1.
- **Read latency:** grant in cycle T gives data_rvalid_o in cycle T+RD_LATENCY, exactly one cycle.
- **data_rdata_o hold:** holds its value until the next RESP cycle.
- **Store latency:** a store is visible to a read granted at T+1 or later.
- **Reset mid-read:** the pending read is discarded and no rvalid is produced. The state after reset is IDLE.
- **Address width:** addr uses the full ADDR_WIDTH. There is no out-of-range case because the array depth matches the address width.
- **Simultaneous req and rst:** no grant and no write.

## Structure
- **Shared defines header:** `DATA_WIDTH, `MEM_ADDR_WIDTH, `MEM_TRANSFER_WIDTH, and the transfer-size encodings (byte/half/word) are added to the shared defines header, so the core and the responder share the encodings.
- **Local constants:** state encodings are localparams in this module.
- **Sub-module data_mem_lane_align:** combinational. Inputs are addr[1:0], size and wdata. Outputs are the shifted wdata, a 4-bit byte enable, and misalign.
- **Top level:** holds the FSM, latency counter, read buffer and byte-enabled RAM array.

## Test plan
- **Word store then load:** RD_LATENCY=1. Store 0xDEADBEEF at 0x010, then load 0x010 on the next cycle. Required: gnt is 1 on both cycles, rvalid is 1 one cycle after the load grant, and rdata=0xDEADBEEF.
- **Byte and half stores:** store byte 0xAA at 0x013, then half 0x1234 at 0x010, over an initial 0x00000000. Required: a load of 0x010 returns 0xAA001234.
- **Misaligned stores:** half store at 0x011, then word store at 0x022. Required: each is granted, data_err_o pulses one cycle after each, and the memory is unchanged.
- **Latency and busy stall:** RD_LATENCY=3. Load granted at T, with req held high afterwards. Required: gnt=0 at T+1 and T+2, rvalid=1 at T+3, and gnt=1 at T+3 for the next request.
- **Back-to-back reads:** RD_LATENCY=1, 4 consecutive loads at 0x0,0x4,0x8,0xC. Required: 4 consecutive rvalid pulses with matching data and no gnt gaps.
- **Reset mid-read:** RD_LATENCY=4, rst asserted at T+2 after a load grant. Required: no rvalid is ever produced, all outputs go to 0, and a new load granted after reset returns the correct data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared bus-width and transfer-size defines plus the responder's common types.
// Core and responder both pull the transfer encodings from here.
`ifndef DATA_MEM_DEFINES_SVH
`define DATA_MEM_DEFINES_SVH
`define DATA_WIDTH          32
`define MEM_ADDR_WIDTH      10
`define MEM_TRANSFER_WIDTH  2
`define MEM_TRANSFER_BYTE   2'b00
`define MEM_TRANSFER_HALF   2'b01
`define MEM_TRANSFER_WORD   2'b10
`endif

package data_mem_responder_pkg;

    typedef enum logic [`MEM_TRANSFER_WIDTH-1:0] {
        XFER_BYTE = `MEM_TRANSFER_BYTE,
        XFER_HALF = `MEM_TRANSFER_HALF,
        XFER_WORD = `MEM_TRANSFER_WORD,
        XFER_RSVD = 2'b11
    } xfer_e;

    localparam int CNT_WIDTH = 3;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-port bus: req/gnt request phase, rvalid response phase.
// master = core memory stage, slave = data_mem_responder.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                           data_req_i;
    logic                           data_wr_i;
    logic [ADDR_WIDTH-1:0]          data_addr_i;
    logic [DATA_WIDTH-1:0]          data_wdata_i;
    logic [`MEM_TRANSFER_WIDTH-1:0] data_write_transfer_i;
    logic                           data_gnt_o;
    logic                           data_rvalid_o;
    logic [DATA_WIDTH-1:0]          data_rdata_o;
    logic                           data_err_o;

    modport master (
        output data_req_i, data_wr_i, data_addr_i, data_wdata_i, data_write_transfer_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_wr_i, data_addr_i, data_wdata_i, data_write_transfer_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/data_mem_lane_align.sv
// Store lane steering: replicates right-justified store data onto all candidate
// lanes and builds the byte enable; misaligned or reserved sizes get no enables.
module data_mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  xfer_e       size,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_sh,
    output logic [3:0]  be,
    output logic        misalign
);

    always_comb begin
        wdata_sh = wdata;
        be       = 4'b0000;
        misalign = 1'b0;
        case (size)
            XFER_BYTE: begin
                wdata_sh = {4{wdata[7:0]}};
                be       = 4'b0001 << addr_lo;
            end
            XFER_HALF: begin
                wdata_sh = {2{wdata[15:0]}};
                if (addr_lo[0]) misalign = 1'b1;
                else            be       = 4'b0011 << addr_lo;
            end
            XFER_WORD: begin
                if (addr_lo != 2'b00) misalign = 1'b1;
                else                  be       = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the core req/gnt/rvalid bus; stores commit at grant,
// loads return after RD_LATENCY cycles, gnt is low while a load is in flight.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT =
        (RD_LATENCY > 1) ? CNT_WIDTH'(RD_LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rbuf_q;
    logic [DATA_WIDTH-1:0]   rdata_hold_q;
    logic                    err_q;

    logic                    ready;
    logic                    gnt;
    logic                    rd_gnt;
    logic                    wr_gnt;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [DATA_WIDTH-1:0]   wdata_sh;
    logic [3:0]              be;
    logic                    misalign;

    data_mem_lane_align u_lane_align (
        .addr_lo  (bus.data_addr_i[1:0]),
        .size     (xfer_e'(bus.data_write_transfer_i)),
        .wdata    (bus.data_wdata_i),
        .wdata_sh (wdata_sh),
        .be       (be),
        .misalign (misalign)
    );

    assign ready    = (state_q == IDLE) || (state_q == RESP);
    assign gnt      = bus.data_req_i && ready && !rst;
    assign rd_gnt   = gnt && !bus.data_wr_i;
    assign wr_gnt   = gnt && bus.data_wr_i;
    assign word_idx = bus.data_addr_i[ADDR_WIDTH-1:2];

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = (state_q == RESP);
    // rbuf is reloaded at every load grant, so outside RESP show the last delivered word
    assign bus.data_rdata_o  = (state_q == RESP) ? rbuf_q : rdata_hold_q;
    assign bus.data_err_o    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (rd_gnt) begin
                    if (RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= wr_gnt && misalign;
            if (state_q == RESP) rdata_hold_q <= rbuf_q;
        end
    end

    // Array and read buffer carry no reset; rd_gnt/wr_gnt are already masked by rst.
    always_ff @(posedge clk) begin
        if (wr_gnt) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
        if (rd_gnt) rbuf_q <= mem[word_idx];
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (read latency 1, 3, 4) on a shared clock/reset, checked every
// cycle against a byte-addressed memory model plus directed literal expectations.
module tb_data_mem_responder;

    localparam int AW = 10;
    localparam int LAT [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    logic          req   [3];
    logic          wr    [3];
    logic [AW-1:0] addr  [3];
    logic [31:0]   wdata [3];
    logic [1:0]    size  [3];
    logic          gnt    [3];
    logic          rvalid [3];
    logic [31:0]   rdata  [3];
    logic          err    [3];

    data_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_conn
        assign bus[g].data_req_i            = req[g];
        assign bus[g].data_wr_i             = wr[g];
        assign bus[g].data_addr_i           = addr[g];
        assign bus[g].data_wdata_i          = wdata[g];
        assign bus[g].data_write_transfer_i = size[g];
        assign gnt[g]    = bus[g].data_gnt_o;
        assign rvalid[g] = bus[g].data_rvalid_o;
        assign rdata[g]  = bus[g].data_rdata_o;
        assign err[g]    = bus[g].data_err_o;
    end

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus[0]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus[1]));
    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .RD_LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: byte-addressed memory, one outstanding load per responder.
    logic [7:0]  mb [int];
    int          busy_until [3];
    bit          pend_v     [3];
    int          pend_due   [3];
    logic [31:0] pend_d     [3];
    logic [31:0] exp_rd     [3];
    bit          err_exp    [3];

    function automatic logic [31:0] model_word(input int i, input int a);
        int base;
        base = i * 4096 + (a & ~3);
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            busy_until[i] = 0; pend_v[i] = 0; pend_due[i] = 0;
            pend_d[i] = '0; exp_rd[i] = '0; err_exp[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                bit exp_v, exp_g;
                int n, a;
                exp_v = pend_v[i] && (pend_due[i] == cyc);
                exp_g = req[i] && !rst && (cyc >= busy_until[i]);
                if (exp_v) exp_rd[i] = pend_d[i];
                chk($sformatf("gnt%0d", i),    {31'b0, gnt[i]},    {31'b0, exp_g});
                chk($sformatf("rvalid%0d", i), {31'b0, rvalid[i]}, {31'b0, exp_v});
                chk($sformatf("rdata%0d", i),  rdata[i],           exp_rd[i]);
                chk($sformatf("err%0d", i),    {31'b0, err[i]},    {31'b0, err_exp[i]});
                if (exp_v) pend_v[i] = 0;
                err_exp[i] = 0;
                if (rst) begin
                    pend_v[i] = 0; busy_until[i] = 0; exp_rd[i] = '0;
                end else if (exp_g) begin
                    a = int'(addr[i]);
                    if (!wr[i]) begin
                        pend_v[i]     = 1;
                        pend_due[i]   = cyc + LAT[i];
                        pend_d[i]     = model_word(i, a);
                        busy_until[i] = cyc + LAT[i];
                    end else begin
                        case (size[i])
                            2'b00:   n = 1;
                            2'b01:   n = 2;
                            2'b10:   n = 4;
                            default: n = 0;
                        endcase
                        if (n == 0 || (a % n) != 0) err_exp[i] = 1;
                        else for (int k = 0; k < n; k++) mb[i*4096 + a + k] = wdata[i][8*k +: 8];
                    end
                end
            end
        end
    end

    // Entered and left at posedge+1; returns the cycle in which the grant was seen.
    task automatic issue(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [1:0] sz, output int g);
        bit granted;
        granted = 0; g = -1;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; size[i] = sz;
        for (int k = 0; k < 20 && !granted; k++) begin
            #1;
            if (gnt[i]) begin granted = 1; g = cyc; end
            @(posedge clk); #1;
        end
        req[i] = 1'b0;
        if (!granted) chk($sformatf("grant_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic wait_rvalid(input int i, input int g, input logic [31:0] exp);
        bit seen;
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (rvalid[i]) begin
                seen = 1;
                chk($sformatf("lat%0d", i), cyc - g, LAT[i]);
                chk($sformatf("data%0d", i), rdata[i], exp);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) chk($sformatf("rvalid_timeout%0d", i), 32'd0, 32'd1);
    endtask

    initial begin
        int g, g1, g2, gp, seen;
        for (int i = 0; i < 3; i++) begin
            req[i] = 0; wr[i] = 0; addr[i] = '0; wdata[i] = '0; size[i] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid0", {31'b0, rvalid[0]}, 32'd0);
        chk("reset_rdata0", rdata[0], 32'd0);
        chk("reset_err0", {31'b0, err[0]}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // word store then load, latency 1
        issue(0, 1, 10'h010, 32'hDEADBEEF, 2'b10, g1);
        issue(0, 0, 10'h010, 32'h0, 2'b00, g2);
        chk("st_ld_consecutive_gnt", g2 - g1, 1);
        wait_rvalid(0, g2, 32'hDEADBEEF);

        // byte then half over a zeroed word
        issue(0, 1, 10'h010, 32'h00000000, 2'b10, g);
        issue(0, 1, 10'h013, 32'hFFFFFFAA, 2'b00, g);
        issue(0, 1, 10'h010, 32'hFFFF1234, 2'b01, g);
        issue(0, 0, 10'h010, 32'h0, 2'b00, g);
        wait_rvalid(0, g, 32'hAA001234);

        // misaligned half / word / reserved-size stores leave memory untouched
        issue(0, 1, 10'h020, 32'h55667788, 2'b10, g);
        issue(0, 1, 10'h011, 32'h0000BBBB, 2'b01, g);
        chk("err_half_mis", {31'b0, err[0]}, 32'd1);
        issue(0, 1, 10'h022, 32'hCCCCCCCC, 2'b10, g);
        chk("err_word_mis", {31'b0, err[0]}, 32'd1);
        issue(0, 1, 10'h020, 32'h99999999, 2'b11, g);
        chk("err_rsvd", {31'b0, err[0]}, 32'd1);
        issue(0, 0, 10'h010, 32'h0, 2'b00, g);
        wait_rvalid(0, g, 32'hAA001234);
        issue(0, 0, 10'h020, 32'h0, 2'b00, g);
        wait_rvalid(0, g, 32'h55667788);

        // latency 3 with the request held high across the busy window
        issue(1, 1, 10'h040, 32'h0BADF00D, 2'b10, g);
        issue(1, 1, 10'h044, 32'h600DCAFE, 2'b10, g);
        issue(1, 0, 10'h040, 32'h0, 2'b00, g1);
        issue(1, 0, 10'h044, 32'h0, 2'b00, g2);
        chk("busy_stall_gap", g2 - g1, 3);
        wait_rvalid(1, g2, 32'h600DCAFE);

        // back-to-back loads at latency 1
        issue(0, 1, 10'h000, 32'h11111111, 2'b10, g);
        issue(0, 1, 10'h004, 32'h22222222, 2'b10, g);
        issue(0, 1, 10'h008, 32'h33333333, 2'b10, g);
        issue(0, 1, 10'h00C, 32'h44444444, 2'b10, g);
        issue(0, 0, 10'h000, 32'h0, 2'b00, gp);
        for (int k = 1; k < 4; k++) begin
            issue(0, 0, 10'(4 * k), 32'h0, 2'b00, g);
            chk("b2b_gnt_gap", g - gp, 1);
            gp = g;
        end
        wait_rvalid(0, g, 32'h44444444);

        // reset two cycles after a latency-4 load grant
        issue(2, 1, 10'h080, 32'hCAFEF00D, 2'b10, g);
        issue(2, 0, 10'h080, 32'h0, 2'b00, g);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rvalid2", {31'b0, rvalid[2]}, 32'd0);
        chk("rst_rdata2", rdata[2], 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        chk("rst_err2", {31'b0, err[2]}, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rvalid[2]) seen++;
            @(posedge clk); #1;
        end
        chk("rst_no_rvalid", seen, 0);
        issue(2, 0, 10'h080, 32'h0, 2'b00, g);
        wait_rvalid(2, g, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
